// File: rtl/ftm_ts_capture_pkg.sv
`default_nettype none
// ============================================================================
// ftm_ts_capture_pkg : shared widths, entry layout and RX FSM encodings
// Rev 1.0
// ============================================================================
package ftm_ts_capture_pkg;

  localparam int FTM_TS_W  = 48;
  localparam int FTM_ENT_W = FTM_TS_W + 1;

  localparam logic [0:0] FTM_RX_IDLE = 1'b0;
  localparam logic [0:0] FTM_RX_PEND = 1'b1;

  typedef struct packed {
    logic                is_rx;
    logic [FTM_TS_W-1:0] ts;
  } ftm_entry_t;

  function automatic logic [7:0] ftm_sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ftm_ts_capture_if.sv
`default_nettype none
// ============================================================================
// ftm_ts_capture_if : timestamp readout valid/ready port
// Rev 1.0
// ============================================================================
interface ftm_ts_capture_if;
  import ftm_ts_capture_pkg::*;

  logic                ts_valid;
  logic                ts_ready;
  logic [FTM_TS_W-1:0] ts_data;
  logic                ts_is_rx;

  modport master (output ts_valid, output ts_data, output ts_is_rx, input ts_ready);
  modport slave  (input ts_valid, input ts_data, input ts_is_rx, output ts_ready);

endinterface
`default_nettype wire

// File: rtl/ftm_ts_fifo.sv
`default_nettype none
// ============================================================================
// ftm_ts_fifo : first-word fall-through timestamp FIFO, head driven from regs
// Rev 1.0
// ============================================================================
module ftm_ts_fifo
  import ftm_ts_capture_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  wire logic                          clk,
  input  wire logic                          rstn,
  input  wire logic                          clear,
  input  wire logic                          wr_en,
  input  wire ftm_entry_t                    wr_data,
  input  wire logic                          rd_en,
  output      ftm_entry_t                    rd_data,
  output      logic                          empty,
  output      logic                          full,
  output      logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [FTM_ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 wr_ok;
  logic                 rd_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign count   = count_q;
  assign rd_data = ftm_entry_t'(mem_q[rd_ptr_q]);

  // When full, a write is only accepted if the head leaves in the same cycle.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (wr_ok && !clear) mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ftm_ts_capture.sv
`default_nettype none
// ============================================================================
// ftm_ts_capture : latency-corrected TX/RX timebase capture with readout FIFO
// Rev 1.0
// ============================================================================
module ftm_ts_capture
  import ftm_ts_capture_pkg::*;
#(
  parameter int unsigned TX_LAT_PS       = 2500,
  parameter int unsigned RX_LAT_PS       = 4000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned FCS_TIMEOUT_CYC = 600000
) (
  input  wire logic                        clk,
  input  wire logic                        rstn,
  input  wire logic [FTM_TS_W-1:0]         ftm_time,
  input  wire logic                        tx_start,
  input  wire logic                        rx_start,
  input  wire logic                        fcs_valid,
  input  wire logic                        fcs_ok,
  input  wire logic                        clear,
  ftm_ts_capture_if.master                 ts,
  output      logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output      logic [7:0]                  ovf_cnt
);

  localparam logic [23:0] TMO_LAST = 24'(FCS_TIMEOUT_CYC - 1);

  logic [FTM_TS_W-1:0] tx_corr, rx_corr;
  logic [FTM_TS_W-1:0] tx_hold_q, tx_hold_d;
  logic                tx_hold_v_q, tx_hold_v_d;
  logic [FTM_TS_W-1:0] rx_cap_q, rx_cap_d;
  logic [0:0]          rx_state_q, rx_state_d;
  logic [23:0]         tmo_q, tmo_d;
  logic [7:0]          ovf_q, ovf_d;
  logic                rx_commit;
  logic                tx_drain;
  logic                tx_ovw;
  logic                wr_en, pop, drop;
  logic                fifo_full, fifo_empty;
  ftm_entry_t          wr_data, head;

  assign tx_corr = ftm_time + FTM_TS_W'(TX_LAT_PS);
  assign rx_corr = ftm_time - FTM_TS_W'(RX_LAT_PS);

  // Old capture is resolved before a same-cycle rx_start recaptures.
  always_comb begin
    rx_state_d = rx_state_q;
    tmo_d      = tmo_q;
    rx_cap_d   = rx_cap_q;
    rx_commit  = 1'b0;
    if (rx_state_q == FTM_RX_PEND) begin
      if (fcs_valid) begin
        rx_commit  = fcs_ok;
        rx_state_d = FTM_RX_IDLE;
      end else if (tmo_q == TMO_LAST) begin
        rx_state_d = FTM_RX_IDLE;
      end else begin
        tmo_d = tmo_q + 24'd1;
      end
    end
    if (rx_start) begin
      rx_cap_d   = rx_corr;
      tmo_d      = '0;
      rx_state_d = FTM_RX_PEND;
    end
    if (clear) begin
      rx_state_d = FTM_RX_IDLE;
      rx_commit  = 1'b0;
    end
  end

  assign tx_drain = tx_hold_v_q & ~rx_commit;
  assign wr_en    = rx_commit | tx_hold_v_q;
  assign wr_data  = rx_commit ? ftm_entry_t'{is_rx: 1'b1, ts: rx_cap_q}
                              : ftm_entry_t'{is_rx: 1'b0, ts: tx_hold_q};
  assign pop      = ~fifo_empty & ts.ts_ready;
  assign drop     = wr_en & fifo_full & ~pop;
  // A hold being drained this cycle is not lost, so only a blocked hold overflows.
  assign tx_ovw   = tx_start & tx_hold_v_q & ~tx_drain;

  always_comb begin
    tx_hold_d   = tx_hold_q;
    tx_hold_v_d = tx_hold_v_q;
    ovf_d       = ftm_sat_add8(ovf_q, {1'b0, drop} + {1'b0, tx_ovw});
    if (tx_start) begin
      tx_hold_d   = tx_corr;
      tx_hold_v_d = 1'b1;
    end else if (tx_drain) begin
      tx_hold_v_d = 1'b0;
    end
    if (clear) begin
      tx_hold_v_d = 1'b0;
      ovf_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_state_q  <= FTM_RX_IDLE;
      tmo_q       <= '0;
      rx_cap_q    <= '0;
      tx_hold_q   <= '0;
      tx_hold_v_q <= 1'b0;
      ovf_q       <= '0;
    end else begin
      rx_state_q  <= rx_state_d;
      tmo_q       <= tmo_d;
      rx_cap_q    <= rx_cap_d;
      tx_hold_q   <= tx_hold_d;
      tx_hold_v_q <= tx_hold_v_d;
      ovf_q       <= ovf_d;
    end
  end

  ftm_ts_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (clear),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (ts.ts_ready),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign ts.ts_valid = ~fifo_empty;
  assign ts.ts_data  = head.ts;
  assign ts.ts_is_rx = head.is_rx;
  assign ovf_cnt     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ftm_ts_capture.sv
`default_nettype none
// ============================================================================
// tb_ftm_ts_capture : directed checks of capture, correction, FIFO and overflow
// Rev 1.0
// ============================================================================
module tb_ftm_ts_capture;

  localparam int unsigned TMO = 20;

  logic        clk = 1'b0;
  logic        rstn;
  logic [47:0] ftm_time;
  logic        tx_start, rx_start, fcs_valid, fcs_ok, clear;
  logic [2:0]  fifo_count;
  logic [7:0]  ovf_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  ftm_ts_capture_if ts_if();

  ftm_ts_capture #(
    .TX_LAT_PS       (2500),
    .RX_LAT_PS       (4000),
    .FIFO_DEPTH      (4),
    .FCS_TIMEOUT_CYC (TMO)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ftm_time   (ftm_time),
    .tx_start   (tx_start),
    .rx_start   (rx_start),
    .fcs_valid  (fcs_valid),
    .fcs_ok     (fcs_ok),
    .clear      (clear),
    .ts         (ts_if),
    .fifo_count (fifo_count),
    .ovf_cnt    (ovf_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tx_evt(input logic [47:0] t);
    ftm_time = t;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
  endtask

  task automatic pop_one();
    ts_if.ts_ready = 1'b1;
    tick();
    ts_if.ts_ready = 1'b0;
  endtask

  logic [47:0] ovf_exp [4];

  initial begin
    rstn = 1'b0; ftm_time = '0; tx_start = 0; rx_start = 0;
    fcs_valid = 0; fcs_ok = 0; clear = 0; ts_if.ts_ready = 0;
    ovf_exp[0] = 48'd2600; ovf_exp[1] = 48'd2700; ovf_exp[2] = 48'd2800; ovf_exp[3] = 48'd2900;
    tick(); tick();
    chk("rst_valid", 64'(ts_if.ts_valid), 64'd0);
    chk("rst_data",  64'(ts_if.ts_data),  64'd0);
    chk("rst_isrx",  64'(ts_if.ts_is_rx), 64'd0);
    chk("rst_count", 64'(fifo_count),     64'd0);
    chk("rst_ovf",   64'(ovf_cnt),        64'd0);
    rstn = 1'b1;
    tick();

    // TX only
    tx_evt(48'd1000);
    chk("tx_valid_n1", 64'(ts_if.ts_valid), 64'd0);
    tick();
    chk("tx_valid_n2", 64'(ts_if.ts_valid), 64'd1);
    chk("tx_data",     64'(ts_if.ts_data),  64'd3500);
    chk("tx_isrx",     64'(ts_if.ts_is_rx), 64'd0);
    chk("tx_count",    64'(fifo_count),     64'd1);
    pop_one();
    chk("tx_pop_count", 64'(fifo_count),    64'd0);

    // RX good
    ftm_time = 48'd10000; rx_start = 1; tick(); rx_start = 0;
    ftm_time = 48'd12345;
    fcs_valid = 1; fcs_ok = 1;
    chk("rx_valid_m", 64'(ts_if.ts_valid), 64'd0);
    tick(); fcs_valid = 0; fcs_ok = 0;
    chk("rx_valid_m1", 64'(ts_if.ts_valid), 64'd1);
    chk("rx_data",     64'(ts_if.ts_data),  64'd6000);
    chk("rx_isrx",     64'(ts_if.ts_is_rx), 64'd1);
    pop_one();

    // RX bad FCS
    ftm_time = 48'd10000; rx_start = 1; tick(); rx_start = 0;
    fcs_valid = 1; fcs_ok = 0; tick(); fcs_valid = 0; tick();
    chk("rxbad_count", 64'(fifo_count),     64'd0);
    chk("rxbad_valid", 64'(ts_if.ts_valid), 64'd0);

    // Wrap-around both directions
    tx_evt(48'hFFFF_FFFF_FC18); tick();
    chk("wrap_tx", 64'(ts_if.ts_data), 64'd1500);
    pop_one();
    ftm_time = 48'd1000; rx_start = 1; tick(); rx_start = 0;
    fcs_valid = 1; fcs_ok = 1; tick(); fcs_valid = 0; fcs_ok = 0;
    chk("wrap_rx",      64'(ts_if.ts_data),  64'h0000_FFFF_FFFF_F448);
    chk("wrap_rx_isrx", 64'(ts_if.ts_is_rx), 64'd1);
    pop_one();

    // TX blocked by RX commit in its write cycle
    ftm_time = 48'd30000; rx_start = 1; tick(); rx_start = 0;
    tx_evt(48'd20000);
    fcs_valid = 1; fcs_ok = 1; tick(); fcs_valid = 0; fcs_ok = 0;
    chk("cont_count1", 64'(fifo_count), 64'd1);
    tick();
    chk("cont_count2", 64'(fifo_count),     64'd2);
    chk("cont_head_rx", 64'(ts_if.ts_is_rx), 64'd1);
    chk("cont_head_d",  64'(ts_if.ts_data),  64'd26000);
    chk("cont_ovf",     64'(ovf_cnt),        64'd0);
    pop_one();
    chk("cont_tx_rx", 64'(ts_if.ts_is_rx), 64'd0);
    chk("cont_tx_d",  64'(ts_if.ts_data),  64'd22500);
    pop_one();

    // Overflow: 6 TX into a 4-deep FIFO, no consumer
    for (int i = 0; i < 6; i++) begin
      tx_evt(48'(100 * (i + 1)));
      tick(); tick();
    end
    chk("ovf_count", 64'(fifo_count), 64'd4);
    chk("ovf_cnt",   64'(ovf_cnt),    64'd2);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_order", 64'(ts_if.ts_data), 64'(ovf_exp[i]));
      pop_one();
    end
    chk("ovf_drained", 64'(ts_if.ts_valid), 64'd0);

    // Clear with 3 queued
    for (int i = 0; i < 3; i++) begin
      tx_evt(48'd500); tick();
    end
    chk("clr_pre_count", 64'(fifo_count), 64'd3);
    clear = 1; tick(); clear = 0;
    chk("clr_count", 64'(fifo_count), 64'd0);
    chk("clr_ovf",   64'(ovf_cnt),    64'd0);

    // RX timeout then late FCS is ignored
    ftm_time = 48'd5000; rx_start = 1; tick(); rx_start = 0;
    repeat (TMO + 2) tick();
    fcs_valid = 1; fcs_ok = 1; tick(); fcs_valid = 0; fcs_ok = 0; tick();
    chk("tmo_count", 64'(fifo_count),     64'd0);
    chk("tmo_valid", 64'(ts_if.ts_valid), 64'd0);

    // Recapture while pending keeps the latest and is not an overflow
    ftm_time = 48'd7000; rx_start = 1; tick(); rx_start = 0; tick();
    ftm_time = 48'd8000; rx_start = 1; tick(); rx_start = 0; tick();
    fcs_valid = 1; fcs_ok = 1; tick(); fcs_valid = 0; fcs_ok = 0;
    chk("recap_count", 64'(fifo_count),    64'd1);
    chk("recap_data",  64'(ts_if.ts_data), 64'd4000);
    chk("recap_ovf",   64'(ovf_cnt),       64'd0);

    // Asynchronous reset mid-operation
    ftm_time = 48'd60; rx_start = 1; tick(); rx_start = 0;
    tx_evt(48'd70);
    #2 rstn = 1'b0;
    #1;
    chk("arst_valid", 64'(ts_if.ts_valid), 64'd0);
    chk("arst_count", 64'(fifo_count),     64'd0);
    chk("arst_ovf",   64'(ovf_cnt),        64'd0);
    tick(); rstn = 1'b1;
    fcs_valid = 1; fcs_ok = 1; tick(); fcs_valid = 0; fcs_ok = 0; tick(); tick();
    chk("arst_lost", 64'(fifo_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
